// File: rtl/uart_axi_arbiter.sv
// uart_axi_arbiter: shares one AXI4-lite master port between two single-beat
// register clients. Client 0 is the UART loader/receive path and client 1 is
// the output/transmit path. Pending requests are served one at a time with
// round-robin fairness.
// Optional statistics counters (c0_count, c1_count, stall_count) are built
// only when the macro UART_AXI_ARB_STATS_EN is defined.

module uart_axi_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,

    // client 0: loader / receive path
    input  logic              c0_en,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_done,
    output logic              c0_busy,
    output logic              c0_err,

    // client 1: output / transmit path
    input  logic              c1_en,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_done,
    output logic              c1_busy,
    output logic              c1_err,

`ifdef UART_AXI_ARB_STATS_EN
    // statistics
    output logic [15:0]       c0_count,
    output logic [15:0]       c1_count,
    output logic [15:0]       stall_count,
`endif

    // AXI4-lite read address / data
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready,

    // AXI4-lite write address / data / response
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // per-client pending slots
    logic              pend0;
    logic              slot0_we;
    logic [ADDR_W-1:0] slot0_addr;
    logic [DATA_W-1:0] slot0_wdata;
    logic              pend1;
    logic              slot1_we;
    logic [ADDR_W-1:0] slot1_addr;
    logic [DATA_W-1:0] slot1_wdata;

    // transaction in service
    logic              cur;
    logic              last_grant;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [3:0]        cur_wstrb;
    logic              aw_ok;
    logic              w_ok;

    // per-client results
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              err0;
    logic              err1;

    // arbitration and handshake helpers
    logic              grant_any;
    logic              grant_id;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              aw_hs;
    logic              w_hs;
    logic              rd_finish;
    logic              wr_finish;
    logic              finish;

    // Round-robin choice: a lone pending slot wins outright, a tie goes to
    // the client that was not granted last.
    always_comb begin
        grant_any   = 1'b0;
        grant_id    = 1'b0;
        if (pend0 && pend1) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
        end else if (pend0) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (pend1) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
        grant_we    = grant_id ? slot1_we    : slot0_we;
        grant_addr  = grant_id ? slot1_addr  : slot0_addr;
        grant_wdata = grant_id ? slot1_wdata : slot0_wdata;
    end

    assign aw_hs     = axi_awvalid && axi_awready;
    assign w_hs      = axi_wvalid && axi_wready;
    assign rd_finish = (state == RD_D) && axi_rvalid && axi_rready;
    assign wr_finish = (state == WR_B) && axi_bvalid && axi_bready;
    assign finish    = rd_finish || wr_finish;

    // State register; reset drops any transaction in flight immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and handshake/pulse outputs derived from the state.
    always_comb begin
        next_state  = state;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        c0_done     = 1'b0;
        c1_done     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    next_state = grant_we ? WR : RD_A;
                end
            end
            RD_A: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    next_state = RD_D;
                end
            end
            RD_D: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    next_state = DONE;
                end
            end
            WR: begin
                axi_awvalid = !aw_ok;
                axi_wvalid  = !w_ok;
                if ((aw_ok || (axi_awready && !aw_ok)) &&
                    (w_ok || (axi_wready && !w_ok))) begin
                    next_state = WR_B;
                end
            end
            WR_B: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                c0_done    = !cur;
                c1_done    = cur;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the granted request and track which write channels are accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur        <= 1'b0;
            last_grant <= 1'b1;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_wstrb  <= 4'h0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                cur        <= grant_id;
                last_grant <= grant_id;
                cur_addr   <= grant_addr;
                aw_ok      <= 1'b0;
                w_ok       <= 1'b0;
                if (grant_we) begin
                    cur_wdata <= grant_wdata;
                    cur_wstrb <= 4'hF;
                end
            end else if (state == WR) begin
                if (aw_hs) begin
                    aw_ok <= 1'b1;
                end
                if (w_hs) begin
                    w_ok <= 1'b1;
                end
            end
        end
    end

    // Client 0 slot: capture when idle, release when its transaction ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend0       <= 1'b0;
            slot0_we    <= 1'b0;
            slot0_addr  <= '0;
            slot0_wdata <= '0;
        end else begin
            if (finish && !cur) begin
                pend0 <= 1'b0;
            end
            if (c0_en && !pend0) begin
                pend0       <= 1'b1;
                slot0_we    <= c0_we;
                slot0_addr  <= c0_addr;
                slot0_wdata <= c0_wdata;
            end
        end
    end

    // Client 1 slot: capture when idle, release when its transaction ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend1       <= 1'b0;
            slot1_we    <= 1'b0;
            slot1_addr  <= '0;
            slot1_wdata <= '0;
        end else begin
            if (finish && cur) begin
                pend1 <= 1'b0;
            end
            if (c1_en && !pend1) begin
                pend1       <= 1'b1;
                slot1_we    <= c1_we;
                slot1_addr  <= c1_addr;
                slot1_wdata <= c1_wdata;
            end
        end
    end

    // Return read data and response status to the client being served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata0 <= '0;
            rdata1 <= '0;
            err0   <= 1'b0;
            err1   <= 1'b0;
        end else if (rd_finish) begin
            if (cur) begin
                rdata1 <= axi_rdata;
                err1   <= (axi_rresp != 2'b00);
            end else begin
                rdata0 <= axi_rdata;
                err0   <= (axi_rresp != 2'b00);
            end
        end else if (wr_finish) begin
            if (cur) begin
                err1 <= (axi_bresp != 2'b00);
            end else begin
                err0 <= (axi_bresp != 2'b00);
            end
        end
    end

    assign c0_busy    = pend0;
    assign c1_busy    = pend1;
    assign c0_rdata   = rdata0;
    assign c1_rdata   = rdata1;
    assign c0_err     = err0;
    assign c1_err     = err1;
    assign axi_araddr = cur_addr;
    assign axi_awaddr = cur_addr;
    assign axi_wdata  = cur_wdata;
    assign axi_wstrb  = cur_wstrb;

`ifdef UART_AXI_ARB_STATS_EN
    logic [1:0] in_service;
    logic [1:0] waiting;

    assign in_service = (state == IDLE) ? 2'b00 : (cur ? 2'b10 : 2'b01);
    assign waiting    = {pend1, pend0} & ~in_service;

    // Completion counters wrap; the stall counter saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c0_count    <= 16'h0000;
            c1_count    <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (c0_done) begin
                c0_count <= c0_count + 16'h0001;
            end
            if (c1_done) begin
                c1_count <= c1_count + 16'h0001;
            end
            if ((waiting != 2'b00) && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_axi_arbiter.sv
// tb_uart_axi_arbiter: directed and randomized bench for uart_axi_arbiter.
// A memory-backed AXI4-lite slave with configurable delays answers the DUT;
// expected service order, read data and error flags come from a round-robin
// model of the two clients over a reference register array.

module tb_uart_axi_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } txn_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              c0_en, c0_we, c1_en, c1_we;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
    logic              c0_done, c0_busy, c0_err, c1_done, c1_busy, c1_err;
    logic [ADDR_W-1:0] axi_araddr, axi_awaddr;
    logic              axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [DATA_W-1:0] axi_rdata, axi_wdata;
    logic [1:0]        axi_rresp, axi_bresp;
    logic              axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]        axi_wstrb;
    logic              axi_bvalid, axi_bready;
`ifdef UART_AXI_ARB_STATS_EN
    logic [15:0]       c0_count, c1_count, stall_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] slave_mem [16];
    logic [31:0] model_mem [16];
    logic [15:0] err_mask;
    bit          rand_dly;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    txn_t        txn_log [$];
    txn_t        exp_txn [$];
    int          got_order [$];
    int          exp_order [$];
    int          got_n [2];
    logic [31:0] got_rd [2];
    logic        got_err [2];
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];
    int          last_grant;
    bit          repulse0, pulse_clear;
    logic        re_we;
    logic [3:0]  re_addr;
    logic [31:0] re_wdata;

    always #5 clk = ~clk;

    uart_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn),
        .c0_en(c0_en), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_rdata(c0_rdata), .c0_done(c0_done), .c0_busy(c0_busy), .c0_err(c0_err),
        .c1_en(c1_en), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_done(c1_done), .c1_busy(c1_busy), .c1_err(c1_err),
`ifdef UART_AXI_ARB_STATS_EN
        .c0_count(c0_count), .c1_count(c1_count), .stall_count(stall_count),
`endif
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
    endtask

    // Slave read: accept the address after a delay, answer after another.
    task automatic slave_read();
        logic [3:0] a;
        int k;
        int t;
        a = axi_araddr;
        k = rand_dly ? int'($urandom_range(0, 3)) : ar_dly;
        repeat (k) begin
            @(negedge clk);
            if (!rstn) begin idle_bus(); return; end
            check_output("ar_hold", {axi_arvalid, axi_araddr}, {1'b1, a});
        end
        axi_arready = 1'b1;
        @(negedge clk);
        if (!rstn) begin idle_bus(); return; end
        axi_arready = 1'b0;
        check_output("ar_accept", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid}, 4'b0100);
        k = rand_dly ? int'($urandom_range(0, 3)) : r_dly;
        repeat (k) begin
            @(negedge clk);
            if (!rstn) begin idle_bus(); return; end
        end
        axi_rvalid = 1'b1;
        axi_rdata  = slave_mem[a];
        axi_rresp  = err_mask[a] ? 2'b10 : 2'b00;
        t = 0;
        while (!axi_rready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_output("r_ready", axi_rready, 1'b1);
        @(negedge clk);
        if (!rstn) begin idle_bus(); return; end
        txn_log.push_back({1'b0, a, axi_rdata, axi_rresp});
        idle_bus();
        check_output("r_drop", axi_rready, 1'b0);
    endtask

    // Slave write: independent address/data accept delays, then response.
    task automatic slave_write();
        logic [3:0]  a;
        logic [31:0] d;
        logic [1:0]  rsp;
        int ka, kw, kb, t;
        a  = axi_awaddr;
        d  = axi_wdata;
        check_output("w_start", {axi_awvalid, axi_wvalid, axi_wstrb}, {2'b11, 4'hF});
        ka = rand_dly ? int'($urandom_range(0, 3)) : aw_dly;
        kw = rand_dly ? int'($urandom_range(0, 3)) : w_dly;
        for (int k = 0; k <= ((ka > kw) ? ka : kw); k++) begin
            if (k > 0) begin
                check_output("aw_valid", axi_awvalid, (k <= ka));
                check_output("w_valid", axi_wvalid, (k <= kw));
                check_output("w_hold", {axi_awaddr, axi_wdata}, {a, d});
            end
            axi_awready = (k == ka);
            axi_wready  = (k == kw);
            @(negedge clk);
            if (!rstn) begin idle_bus(); return; end
        end
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        check_output("b_ready", {axi_awvalid, axi_wvalid, axi_bready}, 3'b001);
        kb = rand_dly ? int'($urandom_range(0, 3)) : b_dly;
        repeat (kb) begin
            @(negedge clk);
            if (!rstn) begin idle_bus(); return; end
        end
        rsp        = err_mask[a] ? 2'b10 : 2'b00;
        axi_bvalid = 1'b1;
        axi_bresp  = rsp;
        t = 0;
        while (!axi_bready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (!rstn) begin idle_bus(); return; end
        slave_mem[a] = d;
        txn_log.push_back({1'b1, a, d, rsp});
        idle_bus();
        check_output("b_drop", axi_bready, 1'b0);
    endtask

    initial begin
        idle_bus();
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && axi_arvalid === 1'b1) begin
                slave_read();
            end else if (rstn === 1'b1 && (axi_awvalid === 1'b1 || axi_wvalid === 1'b1)) begin
                slave_write();
            end
        end
    end

    // Reference effect of one access served for client c.
    task automatic model_access(input int c, input logic we, input logic [3:0] a, input logic [31:0] d);
        txn_t t;
        t.we   = we;
        t.addr = a;
        t.resp = err_mask[a] ? 2'b10 : 2'b00;
        if (we) begin
            t.data       = d;
            model_mem[a] = d;
        end else begin
            t.data       = model_mem[a];
            exp_rdata[c] = model_mem[a];
        end
        exp_err[c] = (t.resp != 2'b00);
        exp_order.push_back(c);
        exp_txn.push_back(t);
    endtask

    // Requests arriving together are served opposite the previous winner.
    task automatic plan(input bit do0, input bit do1,
                        input logic we0, input logic [3:0] a0, input logic [31:0] d0,
                        input logic we1, input logic [3:0] a1, input logic [31:0] d1);
        if (do0 && do1) begin
            if (last_grant == 0) begin
                model_access(1, we1, a1, d1);
                model_access(0, we0, a0, d0);
                last_grant = 0;
            end else begin
                model_access(0, we0, a0, d0);
                model_access(1, we1, a1, d1);
                last_grant = 1;
            end
        end else if (do0) begin
            model_access(0, we0, a0, d0);
            last_grant = 0;
        end else if (do1) begin
            model_access(1, we1, a1, d1);
            last_grant = 1;
        end
    endtask

    task automatic apply_stimulus(input bit do0, input bit do1,
                                  input logic we0, input logic [3:0] a0, input logic [31:0] d0,
                                  input logic we1, input logic [3:0] a1, input logic [31:0] d1);
        @(negedge clk);
        c0_en = do0; c0_we = we0; c0_addr = a0; c0_wdata = d0;
        c1_en = do1; c1_we = we1; c1_addr = a1; c1_wdata = d1;
        @(negedge clk);
        c0_en = 1'b0;
        c1_en = 1'b0;
    endtask

    task automatic sample();
        if (pulse_clear) begin
            c0_en       = 1'b0;
            pulse_clear = 1'b0;
        end
        if (c0_done === 1'b1) begin
            got_n[0]++;
            got_order.push_back(0);
            got_rd[0]  = c0_rdata;
            got_err[0] = c0_err;
            check_output("busy_at_done0", c0_busy, 1'b0);
            if (repulse0) begin
                repulse0    = 1'b0;
                c0_en       = 1'b1;
                c0_we       = re_we;
                c0_addr     = re_addr;
                c0_wdata    = re_wdata;
                pulse_clear = 1'b1;
            end
        end
        if (c1_done === 1'b1) begin
            got_n[1]++;
            got_order.push_back(1);
            got_rd[1]  = c1_rdata;
            got_err[1] = c1_err;
            check_output("busy_at_done1", c1_busy, 1'b0);
        end
    endtask

    // Collect done pulses, then compare everything against the model.
    task automatic check_run(input int n0, input int n1);
        got_n[0] = 0;
        got_n[1] = 0;
        for (int t = 0; t < 300 && (got_n[0] < n0 || got_n[1] < n1); t++) begin
            @(negedge clk);
            sample();
        end
        repeat (4) begin
            @(negedge clk);
            sample();
        end
        check_output("done_count0", got_n[0], n0);
        check_output("done_count1", got_n[1], n1);
        check_output("order_len", got_order.size(), exp_order.size());
        for (int i = 0; i < got_order.size() && i < exp_order.size(); i++) begin
            check_output($sformatf("order%0d", i), got_order[i], exp_order[i]);
        end
        if (n0 > 0) begin
            check_output("rdata0", got_rd[0], exp_rdata[0]);
            check_output("err0", got_err[0], exp_err[0]);
        end
        if (n1 > 0) begin
            check_output("rdata1", got_rd[1], exp_rdata[1]);
            check_output("err1", got_err[1], exp_err[1]);
        end
        check_output("txn_count", txn_log.size(), exp_txn.size());
        for (int i = 0; i < txn_log.size() && i < exp_txn.size(); i++) begin
            check_output($sformatf("txn%0d", i), txn_log[i], exp_txn[i]);
        end
        check_output("idle_busy", {c0_busy, c1_busy}, 2'b00);
        got_order.delete();
        exp_order.delete();
        txn_log.delete();
        exp_txn.delete();
    endtask

    initial begin
        int mode;
        logic we0, we1;
        logic [3:0] a0, a1;
        logic [31:0] d0, d1;
        int t;

        rstn = 1'b1;
        c0_en = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
        c1_en = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
        rand_dly = 0; ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        err_mask = 16'h0000; last_grant = 1;
        repulse0 = 0; pulse_clear = 0; re_we = 0; re_addr = '0; re_wdata = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 0; exp_err[1] = 0;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'hA500_0000 + i;
            model_mem[i] = 32'hA500_0000 + i;
        end
        slave_mem[8] = 32'h0000_0001;
        model_mem[8] = 32'h0000_0001;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        check_output("rst_valid_ready", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 5'b0);
        check_output("rst_addr", {axi_araddr, axi_awaddr}, 8'h00);
        check_output("rst_wdata_wstrb", {axi_wdata, axi_wstrb}, 36'h0);
        check_output("rst_client_flags", {c0_busy, c0_done, c0_err, c1_busy, c1_done, c1_err}, 6'b0);
        check_output("rst_rdata", {c0_rdata, c1_rdata}, 64'h0);
        rstn = 1'b1;

        $display("[TB] c0 read with arvalid latency");
        ar_dly = 0; r_dly = 3;
        plan(1, 0, 0, 4'h8, 32'h0, 0, 4'h0, 32'h0);
        apply_stimulus(1, 0, 0, 4'h8, 32'h0, 0, 4'h0, 32'h0);
        check_output("t1_after_edge1", {c0_busy, axi_arvalid}, 2'b10);
        @(negedge clk);
        check_output("t1_after_edge2", {axi_arvalid, axi_araddr}, {1'b1, 4'h8});
        check_run(1, 0);

        $display("[TB] c1 write, awready before wready");
        aw_dly = 0; w_dly = 2; b_dly = 1;
        plan(0, 1, 0, 4'h0, 32'h0, 1, 4'h4, 32'h41);
        apply_stimulus(0, 1, 0, 4'h0, 32'h0, 1, 4'h4, 32'h41);
        check_run(0, 1);

        $display("[TB] simultaneous requests then c0 again in its done cycle");
        ar_dly = 1; r_dly = 1; aw_dly = 1; w_dly = 1; b_dly = 1;
        repulse0 = 1; re_we = 1; re_addr = 4'h3; re_wdata = 32'h3333_0003;
        plan(1, 1, 0, 4'h8, 32'h0, 1, 4'h2, 32'hCAFE_0002);
        model_access(0, 1, 4'h3, 32'h3333_0003);
        last_grant = 0;
        apply_stimulus(1, 1, 0, 4'h8, 32'h0, 1, 4'h2, 32'hCAFE_0002);
        check_run(2, 1);

        $display("[TB] error response then clean response");
        err_mask = 16'h1000;
        plan(1, 0, 0, 4'hC, 32'h0, 0, 4'h0, 32'h0);
        apply_stimulus(1, 0, 0, 4'hC, 32'h0, 0, 4'h0, 32'h0);
        check_run(1, 0);
        plan(1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
        apply_stimulus(1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
        check_run(1, 0);

        $display("[TB] en re-pulsed while busy");
        r_dly = 6;
        plan(1, 0, 0, 4'h5, 32'h0, 0, 4'h0, 32'h0);
        apply_stimulus(1, 0, 0, 4'h5, 32'h0, 0, 4'h0, 32'h0);
        check_output("t5_busy", c0_busy, 1'b1);
        c0_en = 1'b1; c0_we = 1'b0; c0_addr = 4'h6;
        @(negedge clk);
        c0_en = 1'b0;
        check_run(1, 0);

        $display("[TB] reset while waiting for read data");
        r_dly = 20;
        apply_stimulus(1, 0, 0, 4'h7, 32'h0, 0, 4'h0, 32'h0);
        t = 0;
        while (axi_rready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_output("t6_in_rd_d", axi_rready, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check_output("t6_reset_now", {axi_arvalid, axi_rready, c0_busy, c1_busy}, 4'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        last_grant = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 0; exp_err[1] = 0;
        check_output("t6_rdata_cleared", c0_rdata, 32'h0);
        check_run(0, 0);
        r_dly = 1;
        plan(1, 0, 0, 4'h7, 32'h0, 0, 4'h0, 32'h0);
        apply_stimulus(1, 0, 0, 4'h7, 32'h0, 0, 4'h0, 32'h0);
        check_run(1, 0);

        $display("[TB] randomized traffic");
        rand_dly = 1;
        err_mask = 16'($urandom);
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            we0  = 1'($urandom_range(0, 1));
            we1  = 1'($urandom_range(0, 1));
            a0   = 4'($urandom_range(0, 15));
            a1   = 4'($urandom_range(0, 15));
            d0   = $urandom;
            d1   = $urandom;
            plan(mode != 1, mode != 0, we0, a0, d0, we1, a1, d1);
            apply_stimulus(mode != 1, mode != 0, we0, a0, d0, we1, a1, d1);
            check_run((mode != 1) ? 1 : 0, (mode != 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
